banked_data_mem: RTL and testbench
==================================

BANKED_DATA_MEM -- requirements
Module: banked_data_mem

Interface
REQ-001 SHALL have parameter Ncores, default 2: number of core ports, at least 1.
REQ-002 SHALL have parameter Lmem, default 8: word-address width; total depth is 2^Lmem words.
REQ-003 SHALL have parameter TAM, default 16: data word width in bits.
REQ-004 SHALL have parameter NBANKS, default 4: number of single-port banks; a power of two, at most 2^Lmem.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port dataReq, input, Ncores bits: bit i is core i's access request.
REQ-008 SHALL have port dataWrite, input, Ncores bits: bit i set means core i's request is a write, clear means a read.
REQ-009 SHALL have port dataADDR, input, Ncores*Lmem bits: core i's address in slice [i*Lmem +: Lmem].
REQ-010 SHALL have port dataIN, input, Ncores*TAM bits: core i's write data in slice [i*TAM +: TAM].
REQ-011 SHALL have port dataOUT, output, Ncores*TAM bits: core i's read data in slice [i*TAM +: TAM].
REQ-012 SHALL have port dataAck, output, Ncores bits: bit i is a one-cycle completion pulse for core i.
REQ-013 SHALL have port conflictCnt, output, 16 bits: count of bank conflicts.

Function
REQ-014 SHALL select the bank from address bits [log2(NBANKS)-1:0] and the row within that bank from the remaining upper bits.
REQ-015 SHALL treat core i as requesting in a cycle when dataReq[i]=1 and dataAck[i]=0; dataReq[i] is ignored during a cycle in which dataAck[i]=1.
REQ-016 SHALL grant at most one requesting core per bank per clock edge; requests to different banks are granted in parallel.
REQ-017 SHALL arbitrate each bank independently by round-robin: the search starts at core (rr[b]+1) mod Ncores, and rr[b] is updated to the granted core.
REQ-018 SHALL perform the access at the granting edge: a write updates the word; a read registers the word into core i's dataOUT slice.
REQ-019 SHALL drive dataAck[i]=1 for exactly the cycle after the granting edge, so latency from request to ack is 1 cycle when uncontended.
REQ-020 SHALL hold each dataOUT slice stable until that core's next read grant; a write grant leaves the slice unchanged.
REQ-021 SHALL leave a losing core's request pending with no ack; the core holds its dataReq, dataWrite, dataADDR and dataIN stable until it receives the ack.
REQ-022 SHALL make a read granted at the same edge as another bank's write to the same bank impossible, because only one access per bank is granted per edge.
REQ-023 SHALL guarantee that a continuously requesting core is granted within Ncores edges of contention.

Reset
REQ-024 SHALL, at a rising edge with rst=0, clear all memory words to 0, all dataOUT slices to 0, dataAck to 0, and conflictCnt to 0.
REQ-025 SHALL reset every rr[b] to Ncores-1, so core 0 has first priority.
REQ-026 SHALL let reset override any access at the same edge: no write is performed, no ack is issued, and pending requests are dropped.

Configuration
REQ-027 SHALL compile the conflict counter only when macro BANKED_MEM_CONFLICT_CNT_EN is defined.
REQ-028 SHALL, when BANKED_MEM_CONFLICT_CNT_EN is defined, add 1 to conflictCnt at each edge where a bank has two or more requesters (at most 1 per bank per edge), saturating at 0xFFFF.
REQ-029 SHALL, when BANKED_MEM_CONFLICT_CNT_EN is undefined, tie conflictCnt to 0 and generate no counter logic.

Verification (Ncores=2, Lmem=8, TAM=16, NBANKS=4)
REQ-030 SHALL cover reset: hold rst=0 for 2 cycles, then read 0x00, 0x7F and 0xFF -> dataAck=00 during reset, and every read returns 0x0000.
REQ-031 SHALL cover basic access: core0 writes 0x1234 to 0x05, then reads 0x05 -> each ack arrives 1 cycle after its request, and dataOUT0=0x1234.
REQ-032 SHALL cover parallel banks: core0 writes 0xAAAA to 0x04 and core1 writes 0x5555 to 0x05 in the same cycle -> both acks in the same cycle, and readback gives 0xAAAA and 0x5555.
REQ-033 SHALL cover contention: both cores read bank 1 (0x01, 0x05) in the same cycle, twice -> first round acks core0 then core1; second round acks core1 first; conflictCnt=2 with the macro, 0 without.
REQ-034 SHALL cover reset mid-operation: core0 writes 0xBEEF to 0x10 with rst=0 at the granting edge -> no ack, and a later read of 0x10 returns 0x0000.
REQ-035 SHALL cover saturation: with the macro defined, force more than 65535 conflicts -> conflictCnt holds at 0xFFFF.

Source files
------------

// File: rtl/banked_data_mem.sv
// banked_data_mem: multi-core data memory split into NBANKS single-port banks.
// Each core presents one request at a time. Every bank grants at most one core
// per edge, using its own round-robin pointer. The access happens at the
// granting edge, and dataAck pulses for the following cycle.
// Optional feature: define BANKED_MEM_CONFLICT_CNT_EN to build the saturating
// bank-conflict counter. Without it, conflictCnt is tied to zero.

module banked_data_mem #(
    parameter int Ncores = 2,
    parameter int Lmem   = 8,
    parameter int TAM    = 16,
    parameter int NBANKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Ncores-1:0]      dataReq,
    input  logic [Ncores-1:0]      dataWrite,
    input  logic [Ncores*Lmem-1:0] dataADDR,
    input  logic [Ncores*TAM-1:0]  dataIN,
    output logic [Ncores*TAM-1:0]  dataOUT,
    output logic [Ncores-1:0]      dataAck,
    output logic [15:0]            conflictCnt
);

    localparam int BANK_BITS = $clog2(NBANKS);
    localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROWS      = (1 << Lmem) / NBANKS;
    localparam int RW        = (Lmem - BANK_BITS > 0) ? (Lmem - BANK_BITS) : 1;
    localparam int CW        = (Ncores > 1) ? $clog2(Ncores) : 1;

    // Per-core address decode
    logic [BW-1:0]     bankSel  [Ncores];
    logic [RW-1:0]     rowSel   [Ncores];
    logic [TAM-1:0]    readWord [Ncores];
    logic [Ncores-1:0] active;
    logic [Ncores-1:0] granted;

    // Per-bank arbitration and write port
    logic [Ncores-1:0] bankReq    [NBANKS];
    logic [NBANKS-1:0] gntValid;
    logic [CW-1:0]     gntIdx     [NBANKS];
    logic [CW-1:0]     rr         [NBANKS];
    logic [NBANKS-1:0] bankWe;
    logic [RW-1:0]     bankRow    [NBANKS];
    logic [TAM-1:0]    bankWdata  [NBANKS];

    // Storage: one array per bank
    logic [TAM-1:0]    mem [NBANKS][ROWS];

    // A core that is being acked this cycle already finished its access, so
    // its request line is treated as stale until the ack drops.
    assign active = dataReq & ~dataAck;

    // Split each core's address into a bank (low bits) and a row (high bits).
    always_comb begin
        for (int i = 0; i < Ncores; i++) begin
            bankSel[i]  = BW'(dataADDR[i*Lmem +: Lmem] % NBANKS);
            rowSel[i]   = RW'(dataADDR[i*Lmem +: Lmem] / NBANKS);
            readWord[i] = mem[bankSel[i]][rowSel[i]];
        end
    end

    // Round-robin search per bank, starting one core past the last winner.
    always_comb begin
        logic          found;
        logic [CW-1:0] cand;
        int            c;
        // NOTE: every output gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        found = 1'b0;
        cand  = '0;
        c     = 0;
        for (int b = 0; b < NBANKS; b++) begin
            bankReq[b]   = '0;
            gntValid[b]  = 1'b0;
            gntIdx[b]    = '0;
            for (int i = 0; i < Ncores; i++) begin
                bankReq[b][i] = active[i] && (int'(bankSel[i]) == b);
            end
            found = 1'b0;
            for (int k = 1; k <= Ncores; k++) begin
                c    = (int'(rr[b]) + k) % Ncores;
                cand = CW'(c);
                if (!found && bankReq[b][cand]) begin
                    found     = 1'b1;
                    gntIdx[b] = cand;
                end
            end
            gntValid[b]  = found;
            bankWe[b]    = found && dataWrite[gntIdx[b]];
            bankRow[b]   = rowSel[gntIdx[b]];
            bankWdata[b] = dataIN[gntIdx[b]*TAM +: TAM];
        end
    end

    // A core is granted when the bank it addresses picked it this edge.
    always_comb begin
        for (int i = 0; i < Ncores; i++) begin
            granted[i] = gntValid[bankSel[i]] && (int'(gntIdx[bankSel[i]]) == i);
        end
    end

    // Bank storage: reset clears every word, otherwise each bank takes its granted write.
    always_ff @(posedge clk) begin
        // NOTE: the storage must read back as zero after reset, so it is built
        // from resettable flops rather than a RAM macro without a clear.
        if (!rst) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (bankWe[b]) begin
                    mem[b][bankRow[b]] <= bankWdata[b];
                end
            end
        end
    end

    // Round-robin pointers: remember the last winner per bank; core 0 first after reset.
    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments, so every
        // process samples the pre-edge value regardless of evaluation order.
        if (!rst) begin
            for (int b = 0; b < NBANKS; b++) begin
                rr[b] <= CW'(Ncores - 1);
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (gntValid[b]) begin
                    rr[b] <= gntIdx[b];
                end
            end
        end
    end

    // Core-side outputs: one-cycle ack per grant; read grants load the core's data slice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dataAck <= '0;
            dataOUT <= '0;
        end else begin
            dataAck <= granted;
            for (int i = 0; i < Ncores; i++) begin
                if (granted[i] && !dataWrite[i]) begin
                    dataOUT[i*TAM +: TAM] <= readWord[i];
                end
            end
        end
    end

`ifdef BANKED_MEM_CONFLICT_CNT_EN
    logic [31:0] conflictSum;
    logic [31:0] nextCnt;

    // Count banks that see two or more live requesters this edge.
    always_comb begin
        conflictSum = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if ($countones(bankReq[b]) > 1) begin
                conflictSum = conflictSum + 32'd1;
            end
        end
        nextCnt = 32'(conflictCnt) + conflictSum;
    end

    // Saturating conflict counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflictCnt <= '0;
        end else if (nextCnt > 32'h0000_FFFF) begin
            conflictCnt <= 16'hFFFF;
        end else begin
            conflictCnt <= nextCnt[15:0];
        end
    end
`else
    assign conflictCnt = '0;
`endif

endmodule

// File: tb/tb_banked_data_mem.sv
// Directed self-checking bench for banked_data_mem (Ncores=2, Lmem=8, TAM=16, NBANKS=4).
// Inputs are driven and outputs are sampled on the falling clock edge.
// With BANKED_MEM_CONFLICT_CNT_EN defined, a 16-core instance also exercises counter saturation.

module tb_banked_data_mem;

    logic        clk;
    logic        rst;
    logic [1:0]  dataReq;
    logic [1:0]  dataWrite;
    logic [15:0] dataADDR;
    logic [31:0] dataIN;
    logic [31:0] dataOUT;
    logic [1:0]  dataAck;
    logic [15:0] conflictCnt;

    int checks;
    int errors;

    banked_data_mem #(.Ncores(2), .Lmem(8), .TAM(16), .NBANKS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dataReq    (dataReq),
        .dataWrite  (dataWrite),
        .dataADDR   (dataADDR),
        .dataIN     (dataIN),
        .dataOUT    (dataOUT),
        .dataAck    (dataAck),
        .conflictCnt(conflictCnt)
    );

`ifdef BANKED_MEM_CONFLICT_CNT_EN
    logic [15:0]  satReq;
    logic [15:0]  satWrite;
    logic [127:0] satAddr;
    logic [255:0] satIn;
    logic [255:0] satOut;
    logic [15:0]  satAck;
    logic [15:0]  satCnt;

    // Four cores per bank keep at least three live requesters on every bank each edge.
    banked_data_mem #(.Ncores(16), .Lmem(8), .TAM(16), .NBANKS(4)) dutSat (
        .clk        (clk),
        .rst        (rst),
        .dataReq    (satReq),
        .dataWrite  (satWrite),
        .dataADDR   (satAddr),
        .dataIN     (satIn),
        .dataOUT    (satOut),
        .dataAck    (satAck),
        .conflictCnt(satCnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setCore(input int c, input logic req, input logic wr,
                           input logic [7:0] a, input logic [15:0] d);
        dataReq[c]            = req;
        dataWrite[c]          = wr;
        dataADDR[c*8 +: 8]    = a;
        dataIN[c*16 +: 16]    = d;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [3];
        addrs = '{8'h00, 8'h7F, 8'hFF};
        rst = 1'b0;
        setCore(0, 1'b1, 1'b0, 8'h00, 16'h0000);
        setCore(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (dataAck !== 2'b00) begin
                errors++;
                $display("FAIL reset_ack: got %b expected 00", dataAck);
            end
        end
        rst = 1'b1;
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        checks++;
        if (conflictCnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 0000", conflictCnt);
        end
        for (int k = 0; k < 3; k++) begin
            setCore(0, 1'b1, 1'b0, addrs[k], 16'h0000);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (dataAck !== 2'b01) begin
                errors++;
                $display("FAIL reset_read_ack[%h]: got %b expected 01", addrs[k], dataAck);
            end
            checks++;
            if (dataOUT[15:0] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read_data[%h]: got %h expected 0000", addrs[k], dataOUT[15:0]);
            end
            setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        setCore(0, 1'b1, 1'b1, 8'h05, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL basic_write_ack: got %b expected 01", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL basic_write_keeps_out: got %h expected 0000", dataOUT[15:0]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b00) begin
            errors++;
            $display("FAIL basic_ack_pulse: got %b expected 00", dataAck);
        end
        setCore(0, 1'b1, 1'b0, 8'h05, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL basic_read_ack: got %b expected 01", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL basic_read_data: got %h expected 1234", dataOUT[15:0]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
    endtask

    task automatic test_parallel();
        setCore(0, 1'b1, 1'b1, 8'h04, 16'hAAAA);
        setCore(1, 1'b1, 1'b1, 8'h05, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b11) begin
            errors++;
            $display("FAIL parallel_write_ack: got %b expected 11", dataAck);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setCore(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        setCore(0, 1'b1, 1'b0, 8'h04, 16'h0000);
        setCore(1, 1'b1, 1'b0, 8'h05, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b11) begin
            errors++;
            $display("FAIL parallel_read_ack: got %b expected 11", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'hAAAA) begin
            errors++;
            $display("FAIL parallel_read0: got %h expected AAAA", dataOUT[15:0]);
        end
        checks++;
        if (dataOUT[31:16] !== 16'h5555) begin
            errors++;
            $display("FAIL parallel_read1: got %h expected 5555", dataOUT[31:16]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        setCore(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
    endtask

    // Bank 1 last served core 1 (parallel test), so core 0 wins round one.
    // A solo core-0 write to bank 1 in between makes core 1 the favourite in round two.
    task automatic test_contention();
        logic [15:0] expCnt;
`ifdef BANKED_MEM_CONFLICT_CNT_EN
        expCnt = 16'd2;
`else
        expCnt = 16'd0;
`endif
        setCore(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        setCore(1, 1'b1, 1'b0, 8'h05, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL contend1_first: got %b expected 01", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL contend1_data0: got %h expected 0000", dataOUT[15:0]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b10) begin
            errors++;
            $display("FAIL contend1_second: got %b expected 10", dataAck);
        end
        checks++;
        if (dataOUT[31:16] !== 16'h5555) begin
            errors++;
            $display("FAIL contend1_data1: got %h expected 5555", dataOUT[31:16]);
        end
        setCore(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        setCore(0, 1'b1, 1'b1, 8'h01, 16'hC0DE);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL contend_solo_ack: got %b expected 01", dataAck);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        setCore(0, 1'b1, 1'b0, 8'h01, 16'h0000);
        setCore(1, 1'b1, 1'b0, 8'h05, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b10) begin
            errors++;
            $display("FAIL contend2_first: got %b expected 10", dataAck);
        end
        setCore(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL contend2_second: got %b expected 01", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'hC0DE) begin
            errors++;
            $display("FAIL contend2_data0: got %h expected C0DE", dataOUT[15:0]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        checks++;
        if (conflictCnt !== expCnt) begin
            errors++;
            $display("FAIL contend_cnt: got %0d expected %0d", conflictCnt, expCnt);
        end
    endtask

    task automatic test_reset_mid();
        setCore(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b00) begin
            errors++;
            $display("FAIL midreset_ack: got %b expected 00", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_out_clear: got %h expected 0000", dataOUT[15:0]);
        end
        checks++;
        if (conflictCnt !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_cnt: got %h expected 0000", conflictCnt);
        end
        rst = 1'b1;
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        setCore(0, 1'b1, 1'b0, 8'h10, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dataAck !== 2'b01) begin
            errors++;
            $display("FAIL midreset_read_ack: got %b expected 01", dataAck);
        end
        checks++;
        if (dataOUT[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_read_data: got %h expected 0000", dataOUT[15:0]);
        end
        setCore(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
    endtask

`ifdef BANKED_MEM_CONFLICT_CNT_EN
    // Every bank sees >= 2 live requesters each edge, so the count grows by 4 per edge.
    task automatic test_saturation();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        satReq = '1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (satCnt !== 16'd400) begin
            errors++;
            $display("FAIL sat_rate: got %0d expected 400", satCnt);
        end
        repeat (16400) @(posedge clk);
        @(negedge clk);
        checks++;
        if (satCnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h expected FFFF", satCnt);
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++;
        if (satCnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h expected FFFF", satCnt);
        end
        satReq = '0;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        dataReq   = '0;
        dataWrite = '0;
        dataADDR  = '0;
        dataIN    = '0;
`ifdef BANKED_MEM_CONFLICT_CNT_EN
        satReq   = '0;
        satWrite = '0;
        satIn    = '0;
        for (int i = 0; i < 16; i++) begin
            satAddr[i*8 +: 8] = 8'(i);
        end
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_parallel();
        test_contention();
        test_reset_mid();
`ifdef BANKED_MEM_CONFLICT_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
